// File: rtl/apb_master_bridge_if.sv
// CPU request/response and APB bus signals of the Pep9 APB master bridge.
// master = bridge view, slave = view of the CPU and APB slave around it.
interface apb_master_bridge_if;
  logic        CpuReq;
  logic        CpuWrite;
  logic        CpuWord;
  logic [15:0] CpuAddr;
  logic [15:0] CpuWData;
  logic        CpuAck;
  logic        CpuDone;
  logic        CpuErr;
  logic [15:0] CpuRData;
  logic        Busy;
  logic [15:0] PAddr;
  logic        PSelx;
  logic        PEnable;
  logic        PWrite;
  logic [7:0]  PWData;
  logic        PReady;
  logic [7:0]  PRData;

  modport master (
    input  CpuReq, CpuWrite, CpuWord, CpuAddr, CpuWData, PReady, PRData,
    output CpuAck, CpuDone, CpuErr, CpuRData, Busy, PAddr, PSelx, PEnable, PWrite, PWData
  );

  modport slave (
    output CpuReq, CpuWrite, CpuWord, CpuAddr, CpuWData, PReady, PRData,
    input  CpuAck, CpuDone, CpuErr, CpuRData, Busy, PAddr, PSelx, PEnable, PWrite, PWData
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Pep9 CPU request -> APB SETUP/ACCESS master with one-deep hold register and ACCESS timeout.
// Define PEP9_WORD_ACCESS_EN to turn CpuWord requests into two big-endian byte transfers.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic PClk,
  input logic PReset,
  apb_master_bridge_if.master bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [15:0]   hold_addr;
  logic [7:0]    hold_lo;
  logic          hold_write;
  logic          hold_word;
  logic          second_pending;
  logic [7:0]    hi_byte;
  logic [CW-1:0] wait_count;
  logic [CW-1:0] count_next;
  logic          req_word;

`ifdef PEP9_WORD_ACCESS_EN
  assign req_word = bus.CpuWord;
`else
  logic unused_word;
  assign unused_word = bus.CpuWord;
  assign req_word    = 1'b0;
`endif

  assign count_next = wait_count + 1'b1;

  always_ff @(posedge PClk or posedge PReset) begin
    if (PReset) begin
      state          <= IDLE;
      hold_addr      <= '0;
      hold_lo        <= '0;
      hold_write     <= 1'b0;
      hold_word      <= 1'b0;
      second_pending <= 1'b0;
      hi_byte        <= '0;
      wait_count     <= '0;
      bus.CpuAck     <= 1'b0;
      bus.CpuDone    <= 1'b0;
      bus.CpuErr     <= 1'b0;
      bus.CpuRData   <= '0;
      bus.Busy       <= 1'b0;
      bus.PAddr      <= '0;
      bus.PSelx      <= 1'b0;
      bus.PEnable    <= 1'b0;
      bus.PWrite     <= 1'b0;
      bus.PWData     <= '0;
    end else begin
      bus.CpuAck  <= 1'b0;
      bus.CpuDone <= 1'b0;
      bus.CpuErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CpuReq && !bus.Busy) begin
            hold_addr      <= bus.CpuAddr;
            hold_lo        <= bus.CpuWData[7:0];
            hold_write     <= bus.CpuWrite;
            hold_word      <= req_word;
            second_pending <= req_word;
            bus.CpuAck     <= 1'b1;
            bus.Busy       <= 1'b1;
            // APB outputs are loaded here so they are already valid during SETUP.
            bus.PSelx      <= 1'b1;
            bus.PEnable    <= 1'b0;
            bus.PAddr      <= bus.CpuAddr;
            bus.PWrite     <= bus.CpuWrite;
            bus.PWData     <= req_word ? bus.CpuWData[15:8] : bus.CpuWData[7:0];
            state          <= SETUP;
          end
        end
        SETUP: begin
          bus.PEnable <= 1'b1;
          wait_count  <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.PReady) begin
            if (second_pending) begin
              if (!hold_write) hi_byte <= bus.PRData;
              second_pending <= 1'b0;
              bus.PEnable    <= 1'b0;
              bus.PAddr      <= hold_addr + 16'd1;
              bus.PWData     <= hold_lo;
              state          <= SETUP;
            end else begin
              if (!hold_write)
                bus.CpuRData <= hold_word ? {hi_byte, bus.PRData} : {8'h00, bus.PRData};
              bus.CpuDone <= 1'b1;
              bus.Busy    <= 1'b0;
              bus.PSelx   <= 1'b0;
              bus.PEnable <= 1'b0;
              state       <= IDLE;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (count_next == TIMEOUT_LIMIT)) begin
            // Abort: skip any pending second byte and leave CpuRData untouched.
            second_pending <= 1'b0;
            wait_count     <= '0;
            bus.CpuDone    <= 1'b1;
            bus.CpuErr     <= 1'b1;
            bus.Busy       <= 1'b0;
            bus.PSelx      <= 1'b0;
            bus.PEnable    <= 1'b0;
            state          <= IDLE;
          end else begin
            wait_count <= count_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a behavioural APB memory slave (Mem[i]=i[7:0]).
module tb_apb_master_bridge;

`ifdef PEP9_WORD_ACCESS_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif
  localparam int TIMEOUT = 16;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [15:0] rdata;
  } exp_t;

  logic PClk = 1'b0;
  logic PReset;

  apb_master_bridge_if bus();

  apb_master_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .PClk  (PClk),
    .PReset(PReset),
    .bus   (bus)
  );

  always #5 PClk = ~PClk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // APB slave model and the independent reference memory used for expectations
  logic [7:0] mem       [0:65535];
  logic [7:0] model_mem [0:65535];
  int  wait_states = 0;
  bit  stall       = 1'b0;
  int  wait_cnt    = 0;

  assign bus.PReady = bus.PSelx && bus.PEnable && !stall && (wait_cnt >= wait_states);
  assign bus.PRData = mem[bus.PAddr];

  always @(posedge PClk or posedge PReset) begin
    if (PReset) begin
      wait_cnt <= 0;
    end else if (bus.PSelx && bus.PEnable) begin
      if (bus.PReady) begin
        wait_cnt <= 0;
        if (bus.PWrite) mem[bus.PAddr] <= bus.PWData;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  exp_t        done_q[$];
  logic [23:0] apb_q[$];
  logic [15:0] last_rdata = 16'h0000;

  int          proto_errs = 0;
  int          ack_errs   = 0;
  logic        prev_busy  = 1'b0;
  logic        prev_psel  = 1'b0;
  logic        prev_wait  = 1'b0;
  logic [15:0] prev_addr  = '0;
  logic [7:0]  prev_wdata = '0;
  logic        prev_write = 1'b0;

  // Scoreboard pops and protocol monitors, sampled on the falling edge
  always @(negedge PClk) begin
    exp_t        e;
    logic [23:0] w;
    if (!PReset) begin
      if (bus.CpuDone) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = done_q.pop_front();
          checkOutput("done_err", {31'd0, bus.CpuErr}, {31'd0, e.err});
          if (e.chk_data) checkOutput("done_rdata", {16'd0, bus.CpuRData}, {16'd0, e.rdata});
        end
      end
      if (bus.PSelx && bus.PEnable && bus.PReady && bus.PWrite) begin
        if (apb_q.size() == 0) begin
          checkOutput("unexpected_apb_write", {8'd0, bus.PAddr, bus.PWData}, 32'd0);
        end else begin
          w = apb_q.pop_front();
          checkOutput("apb_write", {8'd0, bus.PAddr, bus.PWData}, {8'd0, w});
        end
      end
      if (bus.PEnable && !bus.PSelx) proto_errs++;
      if (prev_wait && !(bus.CpuDone && bus.CpuErr)) begin
        if (!(bus.PSelx && bus.PEnable)) proto_errs++;
        else if (bus.PAddr != prev_addr || bus.PWData != prev_wdata || bus.PWrite != prev_write)
          proto_errs++;
      end
      if (bus.CpuAck && (prev_busy || prev_psel)) ack_errs++;
    end
    prev_busy  = bus.Busy;
    prev_psel  = bus.PSelx;
    prev_wait  = bus.PSelx && bus.PEnable && !bus.PReady && !PReset;
    prev_addr  = bus.PAddr;
    prev_wdata = bus.PWData;
    prev_write = bus.PWrite;
  end

  task automatic pushExpect(input bit wr, input bit wd, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit exp_err);
    bit          word_eff;
    logic [15:0] a1;
    exp_t        e;
    word_eff = wd && WORD_EN;
    a1       = addr + 16'd1;
    if (exp_err) begin
      e = '{1'b1, 1'b1, last_rdata};
    end else if (wr) begin
      if (word_eff) begin
        apb_q.push_back({addr, wdata[15:8]});
        apb_q.push_back({a1, wdata[7:0]});
        model_mem[addr] = wdata[15:8];
        model_mem[a1]   = wdata[7:0];
      end else begin
        apb_q.push_back({addr, wdata[7:0]});
        model_mem[addr] = wdata[7:0];
      end
      e = '{1'b0, 1'b0, 16'h0000};
    end else begin
      last_rdata = word_eff ? {model_mem[addr], model_mem[a1]} : {8'h00, model_mem[addr]};
      e = '{1'b0, 1'b1, last_rdata};
    end
    done_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit wr, input bit wd, input logic [15:0] addr,
                               input logic [15:0] wdata, input bit exp_err, input string tag);
    int n, setups, access, ready_at, exp_setups, exp_access;
    bit word_eff;
    word_eff   = wd && WORD_EN;
    exp_setups = (exp_err || !word_eff) ? 1 : 2;
    exp_access = exp_err ? TIMEOUT : exp_setups * (wait_states + 1);
    pushExpect(wr, wd, addr, wdata, exp_err);
    @(negedge PClk);
    bus.CpuReq   = 1'b1;
    bus.CpuWrite = wr;
    bus.CpuWord  = wd;
    bus.CpuAddr  = addr;
    bus.CpuWData = wdata;
    n = 0;
    do begin
      @(negedge PClk);
      n++;
    end while (!bus.CpuAck && n < 20);
    bus.CpuReq = 1'b0;
    if (!bus.CpuAck) begin
      checkOutput({tag, "_ack_wait"}, 32'd0, 32'd1);
      return;
    end
    setups = 0; access = 0; ready_at = -1; n = 0;
    while (!bus.CpuDone && n < 200) begin
      if (bus.PSelx && !bus.PEnable) setups++;
      if (bus.PSelx && bus.PEnable) access++;
      if (bus.PReady) ready_at = n;
      @(negedge PClk);
      n++;
    end
    if (!bus.CpuDone) begin
      checkOutput({tag, "_done_wait"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_setups"}, setups, exp_setups);
    checkOutput({tag, "_access"}, access, exp_access);
    if (!exp_err) checkOutput({tag, "_done_latency"}, n - ready_at, 32'd1);
    checkOutput({tag, "_psel_at_done"}, {31'd0, bus.PSelx}, 32'd0);
    checkOutput({tag, "_busy_at_done"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, acks, dones;
    for (int i = 0; i < 65536; i++) begin
      mem[i]       = i[7:0];
      model_mem[i] = i[7:0];
    end
    PReset       = 1'b1;
    bus.CpuReq   = 1'b0;
    bus.CpuWrite = 1'b0;
    bus.CpuWord  = 1'b0;
    bus.CpuAddr  = '0;
    bus.CpuWData = '0;
    repeat (3) @(negedge PClk);
    checkOutput("rst_psel",   {31'd0, bus.PSelx},   32'd0);
    checkOutput("rst_penable",{31'd0, bus.PEnable}, 32'd0);
    checkOutput("rst_busy",   {31'd0, bus.Busy},    32'd0);
    checkOutput("rst_done",   {30'd0, bus.CpuDone, bus.CpuAck}, 32'd0);
    checkOutput("rst_paddr",  {16'd0, bus.PAddr},   32'd0);
    checkOutput("rst_rdata",  {16'd0, bus.CpuRData},32'd0);
    PReset = 1'b0;
    repeat (2) @(negedge PClk);

    // Byte write with one wait state, then read it back
    wait_states = 1;
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h00A5, 1'b0, "t1_wr");
    wait_states = 0;
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, "t1_rd");
    applyStimulus(1'b0, 1'b0, 16'h0123, 16'h0000, 1'b0, "t2_rd");
    wait_states = 2;
    applyStimulus(1'b1, 1'b0, 16'h00FF, 16'h1234, 1'b0, "wr_ff");
    wait_states = 0;
    applyStimulus(1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b0, "rd_ff_word");

    // Slave never ready: timeout abort keeps previous read data
    stall = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, "t3_to");
    stall = 1'b0;

    // Reset in the middle of ACCESS
    stall = 1'b1;
    @(negedge PClk);
    bus.CpuReq   = 1'b1;
    bus.CpuWrite = 1'b0;
    bus.CpuWord  = 1'b0;
    bus.CpuAddr  = 16'h0050;
    n = 0;
    do begin
      @(negedge PClk);
      n++;
    end while (!bus.CpuAck && n < 20);
    bus.CpuReq = 1'b0;
    n = 0;
    while (!bus.PEnable && n < 20) begin
      @(negedge PClk);
      n++;
    end
    checkOutput("t4_in_access", {31'd0, bus.PEnable}, 32'd1);
    repeat (2) @(negedge PClk);
    #2 PReset = 1'b1;
    #1;
    checkOutput("t4_rst_psel_pen", {30'd0, bus.PSelx, bus.PEnable}, 32'd0);
    checkOutput("t4_rst_busy", {31'd0, bus.Busy}, 32'd0);
    last_rdata = 16'h0000;
    stall = 1'b0;
    dones = 0;
    repeat (2) @(negedge PClk);
    PReset = 1'b0;
    repeat (4) begin
      @(negedge PClk);
      if (bus.CpuDone) dones++;
    end
    checkOutput("t4_no_done", dones, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, "t4_after");

    // CpuReq held high across two requests
    pushExpect(1'b0, 1'b0, 16'h0123, 16'h0000, 1'b0);
    pushExpect(1'b0, 1'b0, 16'h0123, 16'h0000, 1'b0);
    @(negedge PClk);
    bus.CpuReq   = 1'b1;
    bus.CpuWrite = 1'b0;
    bus.CpuAddr  = 16'h0123;
    acks = 0; dones = 0; n = 0;
    while (dones < 2 && n < 40) begin
      @(negedge PClk);
      n++;
      if (bus.CpuAck) acks++;
      if (bus.CpuDone) dones++;
    end
    bus.CpuReq = 1'b0;
    checkOutput("t5_acks", acks, 32'd2);
    checkOutput("t5_dones", dones, 32'd2);

`ifdef PEP9_WORD_ACCESS_EN
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1'b0, "t6_wr");
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, "t6_rd");
    checkOutput("t6_rdata", {16'd0, bus.CpuRData}, 32'h0000BEEF);
`endif

    repeat (3) @(negedge PClk);
    checkOutput("protocol_errs", proto_errs, 32'd0);
    checkOutput("ack_while_busy", ack_errs, 32'd0);
    checkOutput("pending_done", done_q.size(), 32'd0);
    checkOutput("pending_apb", apb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
